coalesce_merger: RTL
====================

# coalesce_merger

- Return-path counterpart of the coalescing load/store request splitter.
- Collects coalesced memory sub-responses, one memory block each, for up to 2^CommonReqIdWidth outstanding warp requests.
- Scatters each block's bytes into the per-thread result slots selected by the sub-response member mask and block offsets.
- Emits one complete warp response per request once every expected thread has been served. It sits between the memory response channel and the load/store unit writeback.

## Interface
- NumRequests, 4: threads per warp request.
- BlockIdxBits, 4: log2 of memory block size in bytes; BlockBytes = 2^BlockIdxBits.
- CommonReqIdWidth, 1: width of the warp request ID; NumIds = 2^CommonReqIdWidth table entries.
- WordBytes, 4: bytes returned per thread.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- alloc_valid_i  in  1  register an issued warp request.
- alloc_ready_o  out  1  equals !busy[alloc_id_i].
- alloc_id_i  in  CommonReqIdWidth  warp request ID.
- alloc_mask_i  in  NumRequests  threads expecting a response.
- alloc_we_i  in  1  request is a store; responses are acknowledges only.
- rsp_valid_i  in  1  sub-response present; always accepted, no ready.
- rsp_id_i  in  CommonReqIdWidth  target entry.
- rsp_mask_i  in  NumRequests  threads served by this block.
- rsp_offsets_i  in  NumRequests*BlockIdxBits  per-thread byte offset in block.
- rsp_data_i  in  BlockBytes*8  block data; ignored for stores.
- out_valid_o  out  1  a completed entry is presented.
- out_ready_i  in  1  consumer accepts.
- out_id_o  out  CommonReqIdWidth  ID of presented entry.
- out_mask_o  out  NumRequests  original alloc mask.
- out_we_o  out  1  original alloc we.
- out_data_o  out  NumRequests*WordBytes*8  thread t at bits [t*WordBytes*8 +: WordBytes*8].
- err_o  out  1  one-cycle pulse on an illegal sub-response.

## Operation

Per-entry state, all registered:
- busy
- pending mask
- original mask
- we
- data

Entry lifecycle:
- **FREE (busy=0):** An alloc handshake (alloc_valid_i && alloc_ready_o) moves the entry to busy. It loads pending = original = alloc_mask_i and we, and clears data to zero.
- **WAIT (busy, pending≠0):** A sub-response to this entry clears pending &= ~rsp_mask_i.
  - For loads, each thread t in rsp_mask_i & pending writes byte k (0 ≤ k < WordBytes) from rsp_data_i byte offset_t+k.
  - If offset_t+k ≥ BlockBytes, that byte is written as 0.
- **DONE (busy, pending=0):** The entry is eligible for output. An alloc with an all-zero mask enters DONE directly.
- **Output selection:** out_valid_o = any DONE entry. The lowest-index DONE entry is presented, and out_* are driven combinationally from its state. The out handshake returns that entry to FREE.
- **Illegal sub-responses:** ignored, with err_o pulsed the next cycle. Illegal means either:
  - the addressed entry is not busy, or
  - rsp_mask_i has a bit outside pending.
  - In the second case the legal bits are still applied.
- **Stores:** data stays zero; out_data_o = 0.

## Timing
- **Reset:** all entries FREE; out_valid_o=0, alloc_ready_o=1, out_id_o/out_mask_o/out_we_o/out_data_o=0, err_o=0.
- **Completion latency:** a sub-response that empties pending in cycle t gives out_valid_o=1 in cycle t+1. An all-zero alloc in cycle t gives out_valid_o in t+1.
- **Output stability:** out_valid_o and presented data stay stable until out_ready_i. Exception: a lower-index entry completing may preempt the presented entry while out_ready_i is low.
- **Free/alloc same cycle:** an entry freed by an out handshake in cycle t is allocatable from t+1. There is no same-cycle bypass; alloc_ready_o uses registered busy.
- **Multiple events per cycle:** alloc, sub-response and out handshake in one cycle are all applied when they target different entries. A sub-response cannot legally hit an entry allocated in the same cycle, since that entry is not busy yet.
- **Reset mid-operation:** all outstanding entries are discarded; later sub-responses raise err_o.

## Structure
- Shared package coalesce_pkg:
  - com_req_id_t
  - valid_mask_t
  - block_idx_t / block_offsets_t
  - block_data_t
  - warp_data_t
  - entry state struct
- Sub-module coalesce_block_extractor (combinational): block data plus offsets produce per-thread words with zero fill. One instance feeds all entries.
- Entry table: NumIds-element array of registered structs. Output selection uses a lowest-index priority encoder.

## Test plan
- **Single coalesced load:** alloc id0 mask 4'b1111. One rsp with mask 4'b1111, offsets 0,4,8,12, data bytes 0x00..0x0F. Expect out_data threads = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, out_valid one cycle later.
- **Split load:** alloc mask 4'b1011. Rsp A mask 4'b0001 offset 0, then rsp B mask 4'b1010 offsets 4,8. Expect no out_valid after A; out after B with mask 4'b1011 and thread 2 = 0.
- **Interleaved IDs with backpressure:** id1 completes before id0 while out_ready_i=0. Expect id1 presented, then preempted by id0 when id0 completes. Both delivered exactly once.
- **Store and empty mask:** store alloc mask 4'b0110 with one ack, giving out_we=1 and data 0. Alloc mask 0 gives out_valid the next cycle.
- **Errors:** rsp to a FREE id, and rsp with an already-served thread bit. Expect err_o pulses and no state change for the illegal bits.
- **Reset:** rst_i asserted with two busy entries. Expect all outputs at reset values and alloc_ready_o=1 for both IDs.

Source files
------------

// File: rtl/coalesce_pkg.sv
// Shared types and sizing for the coalescing merger return path.
package coalesce_pkg;

  localparam int NumRequests      = 4;
  localparam int BlockIdxBits     = 4;
  localparam int CommonReqIdWidth = 1;
  localparam int WordBytes        = 4;

  localparam int BlockBytes = 1 << BlockIdxBits;
  localparam int NumIds     = 1 << CommonReqIdWidth;
  localparam int WordBits   = WordBytes * 8;

  typedef logic [CommonReqIdWidth-1:0]          com_req_id_t;
  typedef logic [NumRequests-1:0]               valid_mask_t;
  typedef logic [BlockIdxBits-1:0]              block_idx_t;
  typedef logic [NumRequests*BlockIdxBits-1:0]  block_offsets_t;
  typedef logic [BlockBytes*8-1:0]              block_data_t;
  typedef logic [NumRequests*WordBits-1:0]      warp_data_t;

  // One table slot: FREE when !busy, WAIT while pending has bits, DONE after.
  typedef struct packed {
    logic        busy;
    valid_mask_t pending;
    valid_mask_t mask;
    logic        we;
    warp_data_t  data;
  } entry_t;

endpackage

// File: rtl/coalesce_block_extractor.sv
// Pulls a WordBytes-wide word per thread out of one memory block, starting at
// each thread's byte offset. Bytes that fall past the end of the block read 0.
module coalesce_block_extractor
  import coalesce_pkg::*;
(
  input  logic [BlockBytes*8-1:0]             block_data_i,
  input  logic [NumRequests*BlockIdxBits-1:0] offsets_i,
  output logic [NumRequests*WordBits-1:0]     words_o
);

  localparam int IdxW = BlockIdxBits + 1;

  block_idx_t      off;
  logic [IdxW-1:0] idx;

  // Byte-wise gather with zero fill beyond the block boundary.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    words_o = '0;
    off     = '0;
    idx     = '0;
    for (int t = 0; t < NumRequests; t++) begin
      off = offsets_i[t*BlockIdxBits +: BlockIdxBits];
      for (int k = 0; k < WordBytes; k++) begin
        idx = IdxW'(off) + IdxW'(k);
        if (!idx[BlockIdxBits]) begin
          words_o[(t*WordBytes + k)*8 +: 8] = block_data_i[idx[BlockIdxBits-1:0]*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/coalesce_merger.sv
// Collects per-block sub-responses into per-warp results and hands each
// completed warp request to writeback, lowest table index first.
module coalesce_merger
  import coalesce_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                alloc_valid_i,
  output logic                                alloc_ready_o,
  input  logic [CommonReqIdWidth-1:0]         alloc_id_i,
  input  logic [NumRequests-1:0]              alloc_mask_i,
  input  logic                                alloc_we_i,
  input  logic                                rsp_valid_i,
  input  logic [CommonReqIdWidth-1:0]         rsp_id_i,
  input  logic [NumRequests-1:0]              rsp_mask_i,
  input  logic [NumRequests*BlockIdxBits-1:0] rsp_offsets_i,
  input  logic [BlockBytes*8-1:0]             rsp_data_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [CommonReqIdWidth-1:0]         out_id_o,
  output logic [NumRequests-1:0]              out_mask_o,
  output logic                                out_we_o,
  output logic [NumRequests*WordBits-1:0]     out_data_o,
  output logic                                err_o
);

  entry_t          entry_q [NumIds];
  entry_t          entry_d [NumIds];
  logic            err_q, err_d;
  logic [NumIds-1:0] done;
  com_req_id_t     sel_id;
  logic            sel_valid;
  warp_data_t      rsp_words;
  valid_mask_t     rsp_legal;
  logic            alloc_fire, out_fire;

  coalesce_block_extractor u_extract (
    .block_data_i (rsp_data_i),
    .offsets_i    (rsp_offsets_i),
    .words_o      (rsp_words)
  );

  // Free slots hold pending=0, so this mask is empty for a FREE target.
  assign rsp_legal  = rsp_mask_i & entry_q[rsp_id_i].pending;
  // Registered busy only: a slot freed this cycle is allocatable next cycle.
  assign alloc_ready_o = !entry_q[alloc_id_i].busy;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign out_fire      = sel_valid && out_ready_i;

  // DONE flags and lowest-index priority pick among them.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    for (int i = 0; i < NumIds; i++) begin
      done[i] = entry_q[i].busy && (entry_q[i].pending == '0);
    end
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (done[i]) begin
        sel_valid = 1'b1;
        sel_id    = com_req_id_t'(i);
      end
    end
  end

  // Presented entry, zeroed when nothing is DONE.
  always_comb begin
    out_valid_o = sel_valid;
    out_id_o    = '0;
    out_mask_o  = '0;
    out_we_o    = 1'b0;
    out_data_o  = '0;
    if (sel_valid) begin
      out_id_o   = sel_id;
      out_mask_o = entry_q[sel_id].mask;
      out_we_o   = entry_q[sel_id].we;
      out_data_o = entry_q[sel_id].data;
    end
  end

  // Table update: sub-response scatter, output release, then allocation.
  // Each event can only touch a distinct slot when legal, so order is benign.
  always_comb begin
    entry_d = entry_q;
    err_d   = 1'b0;
    if (rsp_valid_i) begin
      if (!entry_q[rsp_id_i].busy || ((rsp_mask_i & ~entry_q[rsp_id_i].pending) != '0)) begin
        err_d = 1'b1;
      end
      entry_d[rsp_id_i].pending = entry_q[rsp_id_i].pending & ~rsp_legal;
      if (!entry_q[rsp_id_i].we) begin
        for (int t = 0; t < NumRequests; t++) begin
          if (rsp_legal[t]) begin
            entry_d[rsp_id_i].data[t*WordBits +: WordBits] = rsp_words[t*WordBits +: WordBits];
          end
        end
      end
    end
    if (out_fire) begin
      entry_d[sel_id] = '0;
    end
    if (alloc_fire) begin
      entry_d[alloc_id_i] = '{busy: 1'b1, pending: alloc_mask_i, mask: alloc_mask_i,
                              we: alloc_we_i, data: '0};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the table is reset in full: busy must clear, and zeroed data keeps outputs defined.
      for (int i = 0; i < NumIds; i++) begin
        entry_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      entry_q <= entry_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

endmodule
